rr_arbiter8: RTL
================

# rr_arbiter8

Round-robin arbiter that shares a single resource between 8 requesters and drives a one-hot grant through an internal 3-to-8 decoder. It sits in front of any shared datapath that is selected by a 3-bit index, and turns raw request lines into a held, fair, one-hot grant plus the encoded winner index. Each grant is held until the owner drops its request. Selection rotates so that no requester starves.

## Interface
- `NUM_REQ`, 8: number of requesters. Fixed at 8 and tied to the 3-bit index width.
- `TIMEOUT`, 16: maximum number of cycles a grant may be held. Used only when `ARB_TIMEOUT_EN` is defined. Legal range is 2..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  in  8  request lines; bit i high means requester i wants or holds the resource.
- `gnt`  out  8  one-hot grant; all zero when no grant is active.
- `gnt_idx`  out  3  encoded index of the current owner; meaningful only while `gnt_valid` is high.
- `gnt_valid`  out  1  high while a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly revoked. Tied to 0 without `ARB_TIMEOUT_EN`.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one owner holds the resource.
- Priority pointer `ptr` (3 bits). Winner is the first asserted `req` bit found searching `ptr`, `ptr+1`, …, `ptr+7`, modulo 8 (wraps from 7 to 0).
- IDLE:
  - `req == 0`: stay in IDLE.
  - Otherwise: load the winner into `gnt_idx`, set `gnt_valid`, set `ptr = winner+1` (mod 8), go to GRANT.
- GRANT, `req[gnt_idx]` high: hold. `gnt`, `gnt_idx` and `ptr` do not change, whatever other requesters do.
- GRANT, `req[gnt_idx]` low (release):
  - Other requests pending: re-arbitrate in the same cycle and go GRANT→GRANT with the new winner. No idle bubble.
  - No other requests: go to IDLE and clear `gnt_valid`.
- `gnt = gnt_valid ? onehot(gnt_idx) : 8'h00`. At most one bit of `gnt` is ever high.
- New requests arriving during a hold are queued implicitly; they are evaluated at the next release.
- A requester that releases and immediately re-requests goes behind all others, because `ptr` has already advanced past it.
- Reset values: state IDLE, `ptr=0`, `gnt=8'h00`, `gnt_idx=3'd0`, `gnt_valid=0`, `timeout=0`, hold counter 0.
- Reset mid-grant: the grant is dropped on the reset edge. The first arbitration after reset starts from `ptr=0`.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge k gives `gnt` valid after edge k.
- Release-to-handover: 1 cycle. `req[gnt_idx]` low before edge k gives the new `gnt` (or zero) after edge k.
- `gnt` stays high for one cycle after the owner drops `req`. Requesters must tolerate this.
- All outputs are registered. There is no combinational path from `req` to any output.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When the counter reaches `TIMEOUT-1` with `req[gnt_idx]` still high, the grant is revoked at that edge and `timeout` pulses for 1 cycle.
  - Re-arbitration after a revoke masks out the revoked index for that cycle only. If the revoked requester is the only one requesting, the arbiter goes to IDLE for 1 cycle and then re-grants it.
- Undefined:
  - No counter is built and `timeout` is constant 0.
  - A grant is held indefinitely.

## Structure
- Shared package `arb_pkg` holds:
  - `NUM_REQ` and `IDX_W=3`.
  - The `arb_state_t` enum {IDLE, GRANT}.
  - Function `rr_pick(req, ptr, mask)`, which returns winner index and found flag.
- Sub-module `arb_dec3x8`: combinational 3-to-8 decoder with enable (`en=gnt_valid`). Its output feeds the `gnt` register input.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `req=8'hFF` → `gnt=8'h00`, `gnt_valid=0`. After release, first `gnt=8'h01`, `gnt_idx=0`.
- Rotation: `req=8'hFF`, each owner drops `req` for 1 cycle after 2 cycles of grant → grant order 0,1,…,7,0 with no idle cycles between owners.
- Hold: grant requester 3, then raise `req[5]` and `req[1]` while `req[3]` stays high for 10 cycles → `gnt=8'h08` throughout. After `req[3]` drops, next grant is `8'h20`.
- Wrap: `ptr=6` (requester 5 last served), `req=8'h03` → grant `8'h01`, then `8'h02`.
- Empty release: single requester 4 drops `req` → next cycle `gnt=0`, `gnt_valid=0`, state IDLE.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT=4`): `req=8'h05` held high → `gnt=8'h01` for 4 cycles, then `timeout=1` for 1 cycle and `gnt=8'h04`. Repeat the same run without the macro → `gnt=8'h01` forever and `timeout=0`.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating-priority search used by the 8-way arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_t;

  // Result of one round-robin search.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First eligible requester at or after ptr, wrapping modulo NUM_REQ.
  // A set bit in mask excludes that requester from this search.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr,
                                    input logic [NUM_REQ-1:0] mask);
    pick_t              res;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] elig;
    res  = '0;
    elig = req & ~mask;
    // Walk from the far end so the closest hit to ptr is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (elig[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_dec3x8.sv
// Combinational 3-to-8 decoder with enable; all-zero output while disabled.
module arb_dec3x8
  import arb_pkg::*;
(
  input  logic               en,
  input  logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  // Decode idx to a single set bit when enabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with held, registered one-hot grant.
// Optional grant-hold timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("rr_arbiter8: TIMEOUT must be within 2..255");
  end

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               arb;
  logic [NUM_REQ-1:0] mask;
  pick_t              pick;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLast = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Next-state: hold while the owner requests, otherwise re-arbitrate this cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    arb     = 1'b0;
    mask    = '0;
    pick    = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (req[idx_q]) begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q == HoldLast) begin
            // Forced revoke: the revoked owner sits out this one search.
            arb       = 1'b1;
            mask      = NUM_REQ'(1) << idx_q;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end else begin
          arb = 1'b1;
        end
      end
    endcase
    if (arb) begin
      pick = rr_pick(req, ptr_q, mask);
      if (pick.found) begin
        state_d = GRANT;
        idx_d   = pick.idx;
        valid_d = 1'b1;
        ptr_d   = pick.idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    end
  end

  // Decoder runs on next-state values so the registered gnt matches gnt_idx.
  arb_dec3x8 u_dec (
    .en     (valid_d),
    .idx    (idx_d),
    .onehot (gnt_d)
  );

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle revoke pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule
